// File: rtl/ad9850_sweep_ctrl.sv
// ad9850_sweep_ctrl
//   Upstream stage of the AD9850 driver. Converts a frequency in Hz into the
//   32-bit AD9850 tuning word with a sequential shift-add multiplier, runs
//   single-tone or stepped sweeps, hands each tuning word and phase word to
//   the driver over an update_req / upd_done handshake, and holds each step
//   for a programmable dwell time.
//
// Ports
//   sys_clk     system clock
//   rst_n       asynchronous active-low reset
//   start       1-cycle pulse, latches the sweep set-up and begins (IDLE only)
//   stop        1-cycle pulse, aborts the sweep
//   loop_en     1 = restart from f_start after f_stop, 0 = finish
//   f_start     first frequency, Hz (27 bits)
//   f_stop      last frequency, Hz, inclusive (27 bits)
//   f_step      step in Hz, 0 = single tone (27 bits)
//   dwell_us    hold time per step in microseconds (0 behaves as one cycle)
//   phase_in    AD9850 phase word
//   upd_done    driver set-done level; its rising edge acknowledges a transfer
//   ftw         tuning word to the driver
//   phase_word  latched phase word to the driver
//   update_req  1-cycle transfer request
//   busy        high in every state except IDLE
//   sweep_done  1-cycle pulse when a non-looping sweep ends
//   ack_err     sticky handshake-timeout flag, cleared by the next accepted start
module ad9850_sweep_ctrl #(
  parameter int CLK_PER_US  = 50,
  parameter int K_FTW       = 2251800,
  parameter int FRAC        = 16,
  parameter int F_MAX       = 62500000,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic [26:0] f_start,
  input  logic [26:0] f_stop,
  input  logic [26:0] f_step,
  input  logic [15:0] dwell_us,
  input  logic [4:0]  phase_in,
  input  logic        upd_done,
  output logic [31:0] ftw,
  output logic [4:0]  phase_word,
  output logic        update_req,
  output logic        busy,
  output logic        sweep_done,
  output logic        ack_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_SEND,
    S_WAIT_ACK,
    S_DWELL,
    S_STEP,
    S_DONE
  } state_t;

  localparam int                CALC_BITS = 27;
  localparam int                US_W      = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [US_W-1:0]   US_LAST   = US_W'(CLK_PER_US - 1);
  localparam logic [15:0]       ACK_LAST  = 16'(ACK_TIMEOUT - 1);
  localparam logic [26:0]       F_MAX_W   = 27'(F_MAX);
  localparam logic [49:0]       K_EXT     = 50'(K_FTW);
  localparam logic [49:0]       HALF_LSB  = 50'(1) << (FRAC - 1);

  state_t      state, state_nxt;

  // Sweep set-up captured at start; the input pins are free afterwards.
  logic [26:0] f_start_r, f_stop_r, f_step_r;
  logic [15:0] dwell_r;
  logic [4:0]  phase_r;
  logic        loop_r;

  logic [26:0] cur_f;
  logic [26:0] mplier;
  logic [49:0] mcand;
  logic [49:0] prod;
  logic [4:0]  bit_idx;

  logic        upd_q;
  logic        stop_pend;
  logic [15:0] timer;      // WAIT_ACK cycle count, or elapsed microseconds in DWELL
  logic [US_W-1:0] us_cnt;

  logic [27:0] nxt_f;
  logic        wrap;
  logic        upd_rise;
  logic        calc_last;
  logic        dwell_last;
  logic [26:0] next_cur;
  logic [49:0] rounded;

  function automatic logic [26:0] clamp_f(input logic [26:0] f);
    return (f > F_MAX_W) ? F_MAX_W : f;
  endfunction

  // Step arithmetic is one bit wider so cur_f + f_step cannot wrap around.
  assign nxt_f      = {1'b0, cur_f} + {1'b0, f_step_r};
  assign wrap       = (nxt_f > {1'b0, f_stop_r}) || (f_start_r > f_stop_r);
  assign upd_rise   = upd_done & ~upd_q;
  assign calc_last  = (bit_idx == 5'(CALC_BITS));
  assign dwell_last = (dwell_r == 16'd0) ||
                      ((us_cnt == US_LAST) && (timer == dwell_r - 16'd1));
  assign next_cur   = (state == S_IDLE) ? f_start : (wrap ? f_start_r : nxt_f[26:0]);
  assign rounded    = prod + HALF_LSB;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block is given a default before the case, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    update_req = 1'b0;
    busy       = (state != S_IDLE);
    sweep_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        // stop wins over a simultaneous start
        if (start && !stop) state_nxt = S_CALC;
      end
      S_CALC: begin
        if (stop)           state_nxt = S_IDLE;
        else if (calc_last) state_nxt = S_SEND;
      end
      S_SEND: begin
        update_req = 1'b1;
        state_nxt  = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (upd_rise) begin
          if (stop_pend || stop)       state_nxt = S_IDLE;
          else if (f_step_r == 27'd0)  state_nxt = S_DONE;
          else                         state_nxt = S_DWELL;
        end else if (timer == ACK_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      S_DWELL: begin
        if (stop)            state_nxt = S_IDLE;
        else if (dwell_last) state_nxt = S_STEP;
      end
      S_STEP: begin
        if (stop)                 state_nxt = S_IDLE;
        else if (wrap && !loop_r) state_nxt = S_DONE;
        else                      state_nxt = S_CALC;
      end
      S_DONE: begin
        sweep_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      f_start_r  <= '0;
      f_stop_r   <= '0;
      f_step_r   <= '0;
      dwell_r    <= '0;
      phase_r    <= '0;
      loop_r     <= 1'b0;
      cur_f      <= '0;
      mplier     <= '0;
      mcand      <= '0;
      prod       <= '0;
      bit_idx    <= '0;
      upd_q      <= 1'b0;
      stop_pend  <= 1'b0;
      timer      <= '0;
      us_cnt     <= '0;
      ftw        <= '0;
      phase_word <= '0;
      ack_err    <= 1'b0;
    end else begin
      upd_q <= upd_done;

      if (state == S_IDLE && state_nxt == S_CALC) begin
        f_start_r <= f_start;
        f_stop_r  <= f_stop;
        f_step_r  <= f_step;
        dwell_r   <= dwell_us;
        phase_r   <= phase_in;
        loop_r    <= loop_en;
        ack_err   <= 1'b0;
        stop_pend <= 1'b0;
      end

      // Every entry into CALC restarts the multiplier on the (clamped) new frequency.
      if (state_nxt == S_CALC && state != S_CALC) begin
        cur_f   <= next_cur;
        mplier  <= clamp_f(next_cur);
        mcand   <= K_EXT;
        prod    <= '0;
        bit_idx <= '0;
      end

      unique case (state)
        S_CALC: begin
          if (!calc_last) begin
            if (mplier[0]) prod <= prod + mcand;
            mplier  <= mplier >> 1;
            mcand   <= mcand << 1;
            bit_idx <= bit_idx + 5'd1;
          end else begin
            ftw        <= rounded[FRAC +: 32];
            phase_word <= phase_r;
          end
        end
        S_SEND: begin
          timer <= '0;
          if (stop) stop_pend <= 1'b1;
        end
        S_WAIT_ACK: begin
          if (stop) stop_pend <= 1'b1;
          if (upd_rise) begin
            timer  <= '0;
            us_cnt <= '0;
          end else begin
            timer <= timer + 16'd1;
            if (timer == ACK_LAST) ack_err <= 1'b1;
          end
        end
        S_DWELL: begin
          if (us_cnt == US_LAST) begin
            us_cnt <= '0;
            timer  <= timer + 16'd1;
          end else begin
            us_cnt <= us_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
